// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage: retires ALU results and sequences LOAD/STORE accesses.
// Optional memory-wait abort enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opc,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_sdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam logic [5:0] OPC_ADD   = 6'd1;
  localparam logic [5:0] OPC_SUB   = 6'd2;
  localparam logic [5:0] OPC_STORE = 6'd3;
  localparam logic [5:0] OPC_LOAD  = 6'd4;
  localparam logic [5:0] OPC_MOVE  = 6'd5;
  localparam logic [5:0] OPC_SUBI  = 6'd20;
  localparam logic [5:0] OPC_ADDF  = 6'd23;
  localparam logic [5:0] OPC_MULF  = 6'd24;

  typedef enum logic {IDLE, MEM} state_t;

  state_t     state;
  logic [4:0] mem_rd;
  logic       accept_c;
  logic       is_alu_c;
  logic       is_mem_c;
  logic       timeout_c;

  assign in_ready = (state == IDLE);
  assign accept_c = in_valid && in_ready;
  assign is_mem_c = (in_opc == OPC_LOAD) || (in_opc == OPC_STORE);
  assign is_alu_c = (in_opc == OPC_ADD) || (in_opc == OPC_SUB) ||
                    ((in_opc >= OPC_MOVE) && (in_opc <= OPC_SUBI)) ||
                    (in_opc == OPC_ADDF) || (in_opc == OPC_MULF);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Abort fires on the wait cycle that would bring the count to TIMEOUT_CYCLES; an ack wins.
  assign timeout_c = (state == MEM) && !dmem_ack &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= timeout_c;
      if (accept_c && is_mem_c) begin
        tmo_cnt <= '0;
      end else if ((state == MEM) && !dmem_ack) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Stage control: writeback strobe defaults low every cycle; memory fields hold while waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_rd     <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      wb_en      <= 1'b0;
      wb_addr    <= 5'd0;
      wb_data    <= 32'd0;
    end else begin
      wb_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_c && is_mem_c) begin
            state      <= MEM;
            mem_rd     <= in_rd;
            dmem_req   <= 1'b1;
            dmem_we    <= (in_opc == OPC_STORE);
            dmem_addr  <= in_alu;
            dmem_wdata <= in_sdata;
          end else if (accept_c && is_alu_c && (in_rd != 5'd0)) begin
            wb_en   <= 1'b1;
            wb_addr <= in_rd;
            wb_data <= in_alu;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            if (!dmem_we && (mem_rd != 5'd0)) begin
              wb_en   <= 1'b1;
              wb_addr <= mem_rd;
              wb_data <= dmem_rdata;
            end
          end else if (timeout_c) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_wb_stage;

  localparam int unsigned TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opc;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_sdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_rd(in_rd),
    .in_alu(in_alu), .in_sdata(in_sdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcodes whose result is retired to the register file straight from the ALU.
  function automatic bit writes_reg(input logic [5:0] opc);
    return opc inside {6'd1, 6'd2, [6'd5:6'd20], 6'd23, 6'd24};
  endfunction

  // Transaction-level model: one outstanding memory op at most, results as plain values.
  bit          busy = 1'b0;
  bit          pend_load = 1'b0;
  logic [4:0]  pend_rd = '0;
  int unsigned waited = 0;
  logic        m_req = 1'b0, m_we = 1'b0, m_wb_en = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_wb_data = '0;
  logic [4:0]  m_wb_addr = '0;

  always @(posedge clock or posedge reset) begin
    m_wb_en = 1'b0;
    m_err   = 1'b0;
    if (reset) begin
      busy = 1'b0; pend_load = 1'b0; pend_rd = '0; waited = 0;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_wb_addr = '0; m_wb_data = '0;
    end else if (busy) begin
      if (dmem_ack) begin
        busy  = 1'b0;
        m_req = 1'b0;
        if (pend_load && pend_rd != 5'd0) begin
          m_wb_en = 1'b1; m_wb_addr = pend_rd; m_wb_data = dmem_rdata;
        end
      end else begin
        waited++;
`ifdef MEM_TIMEOUT_EN
        if (waited == TMO) begin
          busy = 1'b0; m_req = 1'b0; m_err = 1'b1;
        end
`endif
      end
    end else if (in_valid) begin
      if (in_opc == 6'd3 || in_opc == 6'd4) begin
        busy = 1'b1; pend_load = (in_opc == 6'd4); pend_rd = in_rd; waited = 0;
        m_req = 1'b1; m_we = (in_opc == 6'd3); m_addr = in_alu; m_wdata = in_sdata;
      end else if (writes_reg(in_opc) && in_rd != 5'd0) begin
        m_wb_en = 1'b1; m_wb_addr = in_rd; m_wb_data = in_alu;
      end
    end
  end

  always @(negedge clock) begin
    check("ready",   32'(in_ready),  32'(!busy));
    check("req",     32'(dmem_req),  32'(m_req));
    check("we",      32'(dmem_we),   32'(m_we));
    check("addr",    dmem_addr,      m_addr);
    check("wdata",   dmem_wdata,     m_wdata);
    check("wb_en",   32'(wb_en),     32'(m_wb_en));
    check("wb_addr", 32'(wb_addr),   32'(m_wb_addr));
    check("wb_data", wb_data,        m_wb_data);
    check("mem_err", 32'(mem_err),   32'(m_err));
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic issue(input logic [5:0] opc, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sdata);
    in_valid = 1'b1; in_opc = opc; in_rd = rd; in_alu = alu; in_sdata = sdata;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opc = '0; in_rd = '0; in_alu = '0; in_sdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back ALU results
    issue(6'd1, 5'd5, 32'h0000_0010, 32'd0);
    tick();
    check("add_wb_en", 32'(wb_en), 32'd1);
    check("add_wb_addr", 32'(wb_addr), 32'd5);
    check("add_wb_data", wb_data, 32'h10);
    check("add_model_data", m_wb_data, 32'h10);
    check("add_ready", 32'(in_ready), 32'd1);
    issue(6'd2, 5'd6, 32'hFFFF_FFFF, 32'd0);
    tick();
    check("sub_wb_en", 32'(wb_en), 32'd1);
    check("sub_wb_addr", 32'(wb_addr), 32'd6);
    check("sub_wb_data", wb_data, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    tick();
    check("idle_wb_en", 32'(wb_en), 32'd0);
    check("hold_wb_data", wb_data, 32'hFFFF_FFFF);

    // LOAD with ack in the third request cycle
    issue(6'd4, 5'd7, 32'h100, 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("load_req", 32'(dmem_req), 32'd1);
      check("load_addr", dmem_addr, 32'h100);
      check("load_we", 32'(dmem_we), 32'd0);
      check("load_ready", 32'(in_ready), 32'd0);
      check("load_model_busy", 32'(busy), 32'd1);
      if (i == 2) begin
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    dmem_ack = 1'b0;
    check("load_req_drop", 32'(dmem_req), 32'd0);
    check("load_wb_en", 32'(wb_en), 32'd1);
    check("load_wb_addr", 32'(wb_addr), 32'd7);
    check("load_wb_data", wb_data, 32'hDEAD_BEEF);
    tick();
    check("load_wb_once", 32'(wb_en), 32'd0);

    // STORE acked in its first request cycle
    issue(6'd3, 5'd9, 32'h200, 32'h1234_5678);
    tick();
    in_valid = 1'b0;
    check("store_req", 32'(dmem_req), 32'd1);
    check("store_we", 32'(dmem_we), 32'd1);
    check("store_wdata", dmem_wdata, 32'h1234_5678);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("store_req_drop", 32'(dmem_req), 32'd0);
    check("store_no_wb", 32'(wb_en), 32'd0);
    check("store_ready", 32'(in_ready), 32'd1);

    // r0 writes, JUMP and an undefined opcode are all silent
    issue(6'd1, 5'd0, 32'h55, 32'd0);
    tick();
    check("r0_wb_en", 32'(wb_en), 32'd0);
    issue(6'd21, 5'd3, 32'h66, 32'd0);
    tick();
    check("jump_wb_en", 32'(wb_en), 32'd0);
    issue(6'd63, 5'd4, 32'h77, 32'd0);
    tick();
    check("undef_wb_en", 32'(wb_en), 32'd0);
    check("undef_req", 32'(dmem_req), 32'd0);
    in_valid = 1'b0;

    // Reset in the middle of a LOAD; the late ack must be ignored
    issue(6'd4, 5'd9, 32'h300, 32'd0);
    tick();
    in_valid = 1'b0;
    check("rmid_req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_req_async", 32'(dmem_req), 32'd0);
    check("rmid_addr_async", dmem_addr, 32'd0);
    check("rmid_wb_data_async", wb_data, 32'd0);
    check("rmid_ready_async", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    check("stale_ack_wb", 32'(wb_en), 32'd0);
    check("stale_ack_req", 32'(dmem_req), 32'd0);
    check("stale_ack_ready", 32'(in_ready), 32'd1);

`ifdef MEM_TIMEOUT_EN
    // Abandoned LOAD after TMO wait cycles, then an ack on the last allowed cycle
    issue(6'd4, 5'd10, 32'h400, 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_req_held", 32'(dmem_req), 32'd1);
      tick();
    end
    check("tmo_req_drop", 32'(dmem_req), 32'd0);
    check("tmo_err", 32'(mem_err), 32'd1);
    check("tmo_no_wb", 32'(wb_en), 32'd0);
    tick();
    check("tmo_err_once", 32'(mem_err), 32'd0);
    issue(6'd4, 5'd10, 32'h404, 32'd0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("tmo_edge_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0001;
    tick();
    dmem_ack = 1'b0;
    check("tmo_edge_wb", 32'(wb_en), 32'd1);
    check("tmo_edge_data", wb_data, 32'hA5A5_0001);
    check("tmo_edge_err", 32'(mem_err), 32'd0);
    tick();
`else
    // Without the abort option the request waits as long as needed
    issue(6'd4, 5'd11, 32'h500, 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("wait_req_held", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack = 1'b0;
    check("wait_wb_data", wb_data, 32'h0BAD_F00D);
    check("wait_err", 32'(mem_err), 32'd0);
    tick();
`endif

    // Random traffic, including stray acks while idle and occasional resets
    for (int n = 0; n < 2000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_opc     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(25, 63))
                                               : 6'($urandom_range(0, 24));
      in_rd      = 5'($urandom_range(0, 31));
      in_alu     = $urandom;
      in_sdata   = $urandom;
      dmem_ack   = ($urandom_range(0, 9) < 3);
      dmem_rdata = $urandom;
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; dmem_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, memory-wait cycles before abort; used only when MEM_TIMEOUT_EN is defined.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU stage presents a valid instruction result.
REQ-005 in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 in_opc  input  6  opcode: NOP=0, ADD=1, SUB=2, STORE=3, LOAD=4, MOVE..SUBI=5..20, JUMP=21, BRA=22, ADDF=23, MULF=24.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_alu  input  32  registered ALU result; the memory address for LOAD/STORE.
REQ-009 in_sdata  input  32  store data for STORE.
REQ-010 dmem_req  output  1  data-memory request, held until acknowledged.
REQ-011 dmem_we  output  1  1=write (STORE), 0=read (LOAD).
REQ-012 dmem_addr  output  32  memory address.
REQ-013 dmem_wdata  output  32  memory write data.
REQ-014 dmem_ack  input  1  memory completion strobe.
REQ-015 dmem_rdata  input  32  read data, valid in the ack cycle.
REQ-016 wb_en  output  1  one-cycle register-file write strobe.
REQ-017 wb_addr  output  5  register-file write index.
REQ-018 wb_data  output  32  register-file write data.
REQ-019 mem_err  output  1  one-cycle memory-timeout pulse.

Function
REQ-020 The FSM SHALL have two states, IDLE and MEM; in_ready SHALL be 1 in IDLE and 0 in MEM.
REQ-021 An accepted ALU-class opcode (1, 2, 5-20, 23, 24) SHALL produce, on the next cycle, wb_en=1 with wb_addr=in_rd and wb_data=in_alu; the FSM SHALL stay in IDLE (1-cycle latency, back-to-back accepts allowed).
REQ-022 An accepted NOP, JUMP, BRA or undefined opcode (25-63) SHALL be consumed with no writeback and no memory access.
REQ-023 An accepted LOAD or STORE SHALL move the FSM to MEM, with dmem_req=1 from the next cycle, dmem_addr=in_alu, dmem_we=(opc==STORE) and dmem_wdata=in_sdata.
REQ-024 In MEM, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable until dmem_ack is sampled high.
REQ-025 On dmem_ack in MEM, dmem_req SHALL deassert on the next cycle and the FSM SHALL return to IDLE.
REQ-026 A LOAD SHALL pulse wb_en one cycle after its ack, with wb_data set to the dmem_rdata latched at the ack; a STORE SHALL produce no writeback.
REQ-027 An ack in the first cycle of dmem_req SHALL be honoured, so the minimum memory-access latency is 2 cycles from accept.
REQ-028 dmem_ack SHALL be ignored in IDLE.
REQ-029 A writeback with in_rd=0 SHALL be suppressed (wb_en stays 0), because r0 is read-only.
REQ-030 wb_en SHALL be 0 in every cycle not named above; wb_addr and wb_data SHALL hold their last values.

Reset
REQ-031 reset SHALL force, immediately and without a clock edge: FSM=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_en=0, wb_addr=0, wb_data=0, mem_err=0 and timeout counter=0.
REQ-032 Reset during MEM SHALL abandon the access with no writeback; a later ack for that access SHALL be ignored.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to MEM and increment each MEM cycle without ack.
REQ-035 When that counter reaches TIMEOUT_CYCLES, the stage SHALL drop dmem_req, pulse mem_err for one cycle, write nothing back and return to IDLE.
REQ-036 An ack in the same cycle as timeout SHALL win: normal completion, no mem_err.
REQ-037 Without MEM_TIMEOUT_EN, MEM SHALL wait indefinitely for ack, mem_err SHALL be tied 0 and no counter SHALL be built.

Verification
REQ-038 Accept ADD rd=5 alu=0x0000_0010, then SUB rd=6 alu=0xFFFF_FFFF on consecutive cycles -> wb_en=1 on the following two cycles with (5, 0x10) then (6, 0xFFFFFFFF); in_ready stays 1.
REQ-039 LOAD rd=7 alu=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> req held 3 cycles with addr=0x100 and we=0; one cycle after ack, wb_en=1 with (7, 0xDEADBEEF); in_ready=0 throughout MEM.
REQ-040 STORE alu=0x200 sdata=0x1234_5678, ack on the first req cycle -> one req cycle with we=1 and wdata=0x12345678; wb_en never asserts; in_ready=1 on the next cycle.
REQ-041 ADD rd=0, then JUMP, then opcode 63 -> wb_en stays 0 for all three; no dmem_req.
REQ-042 LOAD issued, reset asserted mid-wait, ack arrives after reset release -> outputs zero immediately on reset; stale ack ignored; no wb_en.
REQ-043 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, LOAD with no ack -> req drops after 4 cycles; mem_err pulses once; no wb_en. A repeat with ack on cycle 4 -> normal writeback, mem_err=0.
